// File: rtl/mem_responder.sv
// mem_responder: multi-channel valid/ready memory endpoint with a fixed response latency.
// Every channel shares one register-array storage, which the host load port can preload.
module mem_responder #(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8,
  parameter int NUM_CHANNELS = 4,
  parameter int LATENCY      = 2,
  parameter int WRITE_ENABLE = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_enable,
  input  logic [ADDR_BITS-1:0]    load_address,
  input  logic [DATA_BITS-1:0]    load_data,
  input  logic [NUM_CHANNELS-1:0] mem_read_valid,
  input  logic [ADDR_BITS-1:0]    mem_read_address [NUM_CHANNELS],
  output logic [NUM_CHANNELS-1:0] mem_read_ready,
  output logic [DATA_BITS-1:0]    mem_read_data [NUM_CHANNELS],
  input  logic [NUM_CHANNELS-1:0] mem_write_valid,
  input  logic [ADDR_BITS-1:0]    mem_write_address [NUM_CHANNELS],
  input  logic [DATA_BITS-1:0]    mem_write_data [NUM_CHANNELS],
  output logic [NUM_CHANNELS-1:0] mem_write_ready
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP, RELEASE} state_t;

  localparam int         DEPTH      = 2 ** ADDR_BITS;
  localparam logic [3:0] COUNT_LOAD = 4'(LATENCY - 1);

  logic [DATA_BITS-1:0]    storage [DEPTH];
  logic [NUM_CHANNELS-1:0] write_req;
  logic [NUM_CHANNELS-1:0] commit;
  logic [ADDR_BITS-1:0]    commit_addr [NUM_CHANNELS];
  logic [DATA_BITS-1:0]    commit_data [NUM_CHANNELS];

  assign write_req = (WRITE_ENABLE != 0) ? mem_write_valid : '0;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
    state_t               state, state_next;
    logic                 is_write;
    logic [3:0]           count;
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0] wdata;
    logic [DATA_BITS-1:0] rdata;
    logic                 take_read, take_write, held;

    assign held = is_write ? write_req[c] : mem_read_valid[c];

    always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
    end

    // Reads win over a simultaneous write; the write is picked up after RELEASE if still held.
    always_comb begin
      state_next = state;
      take_read  = 1'b0;
      take_write = 1'b0;
      case (state)
        IDLE: begin
          if (mem_read_valid[c]) begin
            take_read  = 1'b1;
            state_next = WAIT;
          end else if (write_req[c]) begin
            take_write = 1'b1;
            state_next = WAIT;
          end
        end
        WAIT:    if (count == 4'd0) state_next = RESP;
        RESP:    state_next = RELEASE;
        RELEASE: if (!held) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        is_write <= 1'b0;
        count    <= 4'd0;
        addr     <= '0;
        wdata    <= '0;
        rdata    <= '0;
      end else if (take_read || take_write) begin
        is_write <= take_write;
        count    <= COUNT_LOAD;
        addr     <= take_read ? mem_read_address[c] : mem_write_address[c];
        wdata    <= mem_write_data[c];
      end else if (state == WAIT) begin
        if (count != 4'd0)  count <= count - 4'd1;
        else if (!is_write) rdata <= storage[addr];
      end
    end

    assign mem_read_ready[c]  = (state == RESP) && !is_write;
    assign mem_write_ready[c] = (state == RESP) && is_write;
    assign mem_read_data[c]   = rdata;
    assign commit[c]          = (state == RESP) && is_write && !reset;
    assign commit_addr[c]     = addr;
    assign commit_data[c]     = wdata;
  end

  // Later assignments win: the load port beats every channel, and higher channels beat lower ones.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (commit[c]) storage[commit_addr[c]] <= commit_data[c];
    end
    if (load_enable) storage[load_address] <= load_data;
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized and directed checks of mem_responder against a
// transaction-level memory model (LATENCY=2 main instance, LATENCY=1 read-only instance).
module tb_mem_responder;
  localparam int LAT = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_enable;
  logic [7:0] load_address, load_data;
  logic [3:0] mem_read_valid, mem_read_ready, mem_write_valid, mem_write_ready;
  logic [7:0] rd_addr [4];
  logic [7:0] mem_read_data [4];
  logic [7:0] wr_addr [4];
  logic [7:0] wr_data [4];
  logic [3:0] ro_read_valid, ro_read_ready, ro_write_valid, ro_write_ready;
  logic [7:0] ro_read_data [4];

  logic [7:0] model [256];
  logic [7:0] model_ro [256];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CHANNELS(4), .LATENCY(LAT), .WRITE_ENABLE(1)) dut (
    .clk(clk), .reset(reset),
    .load_enable(load_enable), .load_address(load_address), .load_data(load_data),
    .mem_read_valid(mem_read_valid), .mem_read_address(rd_addr),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .mem_write_valid(mem_write_valid), .mem_write_address(wr_addr),
    .mem_write_data(wr_data), .mem_write_ready(mem_write_ready)
  );

  mem_responder #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CHANNELS(4), .LATENCY(1), .WRITE_ENABLE(0)) dut_ro (
    .clk(clk), .reset(reset),
    .load_enable(load_enable), .load_address(load_address), .load_data(load_data),
    .mem_read_valid(ro_read_valid), .mem_read_address(rd_addr),
    .mem_read_ready(ro_read_ready), .mem_read_data(ro_read_data),
    .mem_write_valid(ro_write_valid), .mem_write_address(wr_addr),
    .mem_write_data(wr_data), .mem_write_ready(ro_write_ready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [7:0] a, input logic [7:0] d);
    load_enable  = 1'b1;
    load_address = a;
    load_data    = d;
    step();
    load_enable  = 1'b0;
    model[a]     = d;
    model_ro[a]  = d;
  endtask

  // One simultaneous transaction per selected channel, following the initiator handshake.
  task automatic run_batch(input string name, input logic [3:0] rmask, input logic [3:0] wmask,
                           input bit do_load, input logic [7:0] la, input logic [7:0] ld);
    logic [7:0] exp_data [4];
    for (int c = 0; c < 4; c++) exp_data[c] = model[rd_addr[c]];
    mem_read_valid  = rmask;
    mem_write_valid = wmask;
    step();
    for (int k = 0; k < LAT; k++) begin
      checks++;
      if (mem_read_ready !== 4'b0 || mem_write_ready !== 4'b0) begin
        errors++;
        $display("[TB] FAIL %s early_ready cycle %0d: got r=%b w=%b, required 0000/0000",
                 name, k, mem_read_ready, mem_write_ready);
      end
      step();
    end
    checks++;
    if (mem_read_ready !== rmask || mem_write_ready !== wmask) begin
      errors++;
      $display("[TB] FAIL %s ready: got r=%b w=%b, required r=%b w=%b",
               name, mem_read_ready, mem_write_ready, rmask, wmask);
    end
    for (int c = 0; c < 4; c++) begin
      if (rmask[c]) begin
        checks++;
        if (mem_read_data[c] !== exp_data[c]) begin
          errors++;
          $display("[TB] FAIL %s ch%0d read_data: got %h, required %h",
                   name, c, mem_read_data[c], exp_data[c]);
        end
      end
    end
    mem_read_valid  = 4'b0;
    mem_write_valid = 4'b0;
    for (int c = 0; c < 4; c++) if (wmask[c]) model[wr_addr[c]] = wr_data[c];
    if (do_load) begin
      load_enable  = 1'b1;
      load_address = la;
      load_data    = ld;
      model[la]    = ld;
      model_ro[la] = ld;
    end
    step();
    load_enable = 1'b0;
    checks++;
    if (mem_read_ready !== 4'b0 || mem_write_ready !== 4'b0) begin
      errors++;
      $display("[TB] FAIL %s ready_after: got r=%b w=%b, required 0000/0000",
               name, mem_read_ready, mem_write_ready);
    end
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if (mem_read_ready !== 4'b0 || mem_write_ready !== 4'b0 ||
        ro_read_ready !== 4'b0 || ro_write_ready !== 4'b0) begin
      errors++;
      $display("[TB] FAIL reset_ready: got r=%b w=%b ro_r=%b ro_w=%b, required all 0",
               mem_read_ready, mem_write_ready, ro_read_ready, ro_write_ready);
    end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (mem_read_data[c] !== 8'h00) begin
        errors++;
        $display("[TB] FAIL reset_data ch%0d: got %h, required 00", c, mem_read_data[c]);
      end
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_load_and_read();
    load_word(8'h10, 8'h5A);
    rd_addr[0] = 8'h10;
    run_batch("load_read", 4'b0001, 4'b0000, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic test_parallel_reads();
    for (int c = 0; c < 4; c++) load_word(8'(c), 8'(8'hA0 + c));
    for (int c = 0; c < 4; c++) rd_addr[c] = 8'(c);
    run_batch("parallel", 4'b1111, 4'b0000, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic test_write_collision();
    wr_addr[1] = 8'h20; wr_data[1] = 8'h11;
    wr_addr[3] = 8'h20; wr_data[3] = 8'h33;
    run_batch("collision", 4'b0000, 4'b1010, 1'b0, 8'h00, 8'h00);
    rd_addr[0] = 8'h20;
    run_batch("collision_read", 4'b0001, 4'b0000, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic test_load_priority();
    wr_addr[3] = 8'h20; wr_data[3] = 8'h33;
    run_batch("load_prio", 4'b0000, 4'b1000, 1'b1, 8'h20, 8'h77);
    rd_addr[2] = 8'h20;
    run_batch("load_prio_read", 4'b0100, 4'b0000, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic test_held_valid();
    rd_addr[0] = 8'h10;
    mem_read_valid = 4'b0001;
    step();
    for (int k = 0; k < LAT; k++) begin
      checks++;
      if (mem_read_ready !== 4'b0) begin
        errors++;
        $display("[TB] FAIL held_early cycle %0d: got %b, required 0000", k, mem_read_ready);
      end
      step();
    end
    checks++;
    if (mem_read_ready !== 4'b0001 || mem_read_data[0] !== model[8'h10]) begin
      errors++;
      $display("[TB] FAIL held_first: got r=%b d=%h, required r=0001 d=%h",
               mem_read_ready, mem_read_data[0], model[8'h10]);
    end
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (mem_read_ready !== 4'b0) begin
        errors++;
        $display("[TB] FAIL held_repeat cycle %0d: got %b, required 0000", k, mem_read_ready);
      end
    end
    mem_read_valid = 4'b0;
    step();
    mem_read_valid = 4'b0001;
    step();
    for (int k = 0; k < LAT; k++) begin
      checks++;
      if (mem_read_ready !== 4'b0) begin
        errors++;
        $display("[TB] FAIL held_reaccept_early cycle %0d: got %b, required 0000", k, mem_read_ready);
      end
      step();
    end
    checks++;
    if (mem_read_ready !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL held_reaccept: got %b, required 0001", mem_read_ready);
    end
    mem_read_valid = 4'b0;
    step();
    step();
  endtask

  task automatic test_mid_reset();
    load_word(8'h40, 8'h4C);
    load_word(8'h41, 8'h4D);
    rd_addr[0] = 8'h41;
    wr_addr[1] = 8'h40; wr_data[1] = 8'hFF;
    mem_read_valid  = 4'b0001;
    mem_write_valid = 4'b0010;
    step();
    reset = 1'b1;
    step();
    checks++;
    if (mem_read_ready !== 4'b0 || mem_write_ready !== 4'b0) begin
      errors++;
      $display("[TB] FAIL midreset_ready: got r=%b w=%b, required 0000/0000",
               mem_read_ready, mem_write_ready);
    end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (mem_read_data[c] !== 8'h00) begin
        errors++;
        $display("[TB] FAIL midreset_data ch%0d: got %h, required 00", c, mem_read_data[c]);
      end
    end
    reset = 1'b0;
    mem_read_valid  = 4'b0;
    mem_write_valid = 4'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (mem_read_ready !== 4'b0 || mem_write_ready !== 4'b0) begin
        errors++;
        $display("[TB] FAIL midreset_quiet cycle %0d: got r=%b w=%b, required 0000/0000",
                 k, mem_read_ready, mem_write_ready);
      end
    end
    rd_addr[0] = 8'h40;
    rd_addr[1] = 8'h41;
    run_batch("midreset_storage", 4'b0011, 4'b0000, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic test_write_disabled();
    load_word(8'h30, 8'h3C);
    wr_addr[0] = 8'h30; wr_data[0] = 8'hEE;
    ro_write_valid = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (ro_write_ready !== 4'b0) begin
        errors++;
        $display("[TB] FAIL we0_write_ready cycle %0d: got %b, required 0000", k, ro_write_ready);
      end
    end
    ro_write_valid = 4'b0;
    step();
    rd_addr[0] = 8'h30;
    ro_read_valid = 4'b0001;
    step();
    checks++;
    if (ro_read_ready !== 4'b0) begin
      errors++;
      $display("[TB] FAIL we0_read_early: got %b, required 0000", ro_read_ready);
    end
    step();
    checks++;
    if (ro_read_ready !== 4'b0001 || ro_read_data[0] !== model_ro[8'h30]) begin
      errors++;
      $display("[TB] FAIL we0_read: got r=%b d=%h, required r=0001 d=%h",
               ro_read_ready, ro_read_data[0], model_ro[8'h30]);
    end
    ro_read_valid = 4'b0;
    step();
    checks++;
    if (ro_read_ready !== 4'b0) begin
      errors++;
      $display("[TB] FAIL we0_read_after: got %b, required 0000", ro_read_ready);
    end
    step();
  endtask

  // Back-to-back random batches on a small address window so collisions and read-after-write occur.
  task automatic test_random();
    logic [3:0] rmask, wmask;
    for (int a = 0; a < 16; a++) load_word(8'(a), 8'($urandom_range(0, 255)));
    for (int n = 0; n < 25; n++) begin
      rmask = 4'($urandom_range(0, 15));
      wmask = 4'($urandom_range(0, 15)) & ~rmask;
      if (rmask == 4'b0 && wmask == 4'b0) rmask = 4'b0001;
      for (int c = 0; c < 4; c++) begin
        rd_addr[c] = 8'($urandom_range(0, 15));
        wr_addr[c] = 8'($urandom_range(0, 15));
        wr_data[c] = 8'($urandom_range(0, 255));
      end
      run_batch($sformatf("random%0d", n), rmask, wmask, 1'b0, 8'h00, 8'h00);
    end
  endtask

  initial begin
    reset           = 1'b1;
    load_enable     = 1'b0;
    load_address    = 8'h00;
    load_data       = 8'h00;
    mem_read_valid  = 4'b0;
    mem_write_valid = 4'b0;
    ro_read_valid   = 4'b0;
    ro_write_valid  = 4'b0;
    for (int c = 0; c < 4; c++) begin
      rd_addr[c] = 8'h00;
      wr_addr[c] = 8'h00;
      wr_data[c] = 8'h00;
    end
    test_reset();
    test_load_and_read();
    test_parallel_reads();
    test_write_collision();
    test_load_priority();
    test_held_valid();
    test_mid_reset();
    test_write_disabled();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Synthesizable multi-channel memory responder. It is the memory end of the valid/ready read/write channel protocol that the gpu memory controllers initiate.
- It replaces the external async memory for FPGA builds and for self-contained RTL simulation.
- Each channel runs an independent request FSM with a fixed, configurable response latency.
- All channels share one register-array storage, which a host load port can preload before a kernel runs.

Parameters:
- ADDR_BITS, 8: address width; storage depth is 2**ADDR_BITS words.
- DATA_BITS, 8: word width (use 16 for program memory).
- NUM_CHANNELS, 4: number of independent request channels.
- LATENCY, 2: cycles from request acceptance to ready; legal range 1..15.
- WRITE_ENABLE, 1: when 0, write channels are ignored (write_ready is held at 0) and only the load port writes.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- load_enable  in  1  host preload strobe
- load_address  in  ADDR_BITS  host preload address
- load_data  in  DATA_BITS  host preload data
- mem_read_valid  in  NUM_CHANNELS  per-channel read request
- mem_read_address  in  ADDR_BITS x NUM_CHANNELS (unpacked)  read address
- mem_read_ready  out  NUM_CHANNELS  read response strobe
- mem_read_data  out  DATA_BITS x NUM_CHANNELS (unpacked)  read data
- mem_write_valid  in  NUM_CHANNELS  per-channel write request
- mem_write_address  in  ADDR_BITS x NUM_CHANNELS (unpacked)  write address
- mem_write_data  in  DATA_BITS x NUM_CHANNELS (unpacked)  write data
- mem_write_ready  out  NUM_CHANNELS  write completion strobe

Behaviour:
- Reset (synchronous, active-high), outputs: all mem_read_ready = 0, all mem_write_ready = 0, all mem_read_data = 0.
- Reset, internal state: all channel FSMs go to IDLE and all latency counters clear.
- Reset does NOT clear storage contents.
- Reset asserted mid-transaction aborts that transaction: no ready is issued and no write is committed.
- Per-channel FSM states: IDLE, WAIT, RESP, RELEASE.
- IDLE: when mem_read_valid or mem_write_valid is sampled high, latch the type, address and write data, load the counter with LATENCY-1, and go to WAIT.
  - If both valids are high in the same cycle, the read is taken first. The write is taken after RELEASE if it is still asserted.
- WAIT: decrement the counter each cycle. At 0:
  - for a read, capture storage[addr] into mem_read_data;
  - go to RESP.
- RESP: assert the matching ready for exactly one cycle.
  - A write commits to storage on this cycle's clock edge.
  - Next state is RELEASE.
- RELEASE: ready = 0. Stay until the latched request type's valid is sampled low, then go to IDLE.
  - The initiator drops valid one cycle after it sees ready. A back-to-back request therefore costs 1 idle cycle minimum.
- Latency: valid sampled at edge t gives ready high after edge t+LATENCY, visible during cycle t+LATENCY.
- mem_read_data holds its captured value until the channel's next read capture.
- Requests arriving in WAIT/RESP/RELEASE are not accepted. Address/data changes after acceptance are ignored.
- Write collisions in the same cycle: priority is load port > higher-numbered channel > lower-numbered channel. Only the winner's value is stored; all colliding channels still see write_ready.
- Read/write to the same address: a read captured on the same edge as a write commit returns the old value.
- WRITE_ENABLE=0: mem_write_valid is ignored entirely; the FSM never enters WAIT for a write.
- load_enable: writes storage on the next edge, independent of channel FSM state.
- All arithmetic is unsigned. The counter is 4 bits and LATENCY=1 means WAIT lasts one cycle.

Test Plan:
- Load and read: preload addr 0x10 = 0x5A via the load port, then ch0 read 0x10 with LATENCY=2. Required: read_ready pulses once, 2 cycles after valid is sampled, with read_data = 0x5A; ready is low the next cycle.
- Parallel reads: ch0..ch3 read 0x00..0x03 (preloaded 0xA0..0xA3) in the same cycle. Required: all four readies pulse on the same cycle with data 0xA0..0xA3 respectively.
- Write collision: ch1 writes 0x20 = 0x11 and ch3 writes 0x20 = 0x33 in the same cycle, then read 0x20. Required: both write_ready pulse, and the read returns 0x33.
- Load priority: load_enable writes 0x20 = 0x77 on the same edge ch3 commits 0x20 = 0x33. Required: a later read returns 0x77.
- Held valid: ch0 keeps read_valid high 5 cycles past ready. Required: a single ready pulse and no second acceptance until valid has been low for 1 cycle.
- Mid-operation reset: reset asserted during WAIT. Required: no ready pulse, all outputs 0 the following cycle, and storage still holds its preloaded values.
- WRITE_ENABLE=0: a write request on ch0 never produces write_ready and storage is unchanged.
